// File: rtl/jt12_div_pkg.sv
// Shared definitions for the FM prescaler controller: divider codes, register addresses,
// FSM encoding and the code-to-period mapping.
package jt12_div_pkg;

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned SETTLE_W = 3;
    localparam int unsigned CODE_W   = 2;

    localparam logic [CODE_W-1:0] DIV6 = 2'd0;
    localparam logic [CODE_W-1:0] DIV3 = 2'd1;
    localparam logic [CODE_W-1:0] DIV2 = 2'd2;

    localparam logic [7:0] ADDR_DIV6 = 8'h2D;
    localparam logic [7:0] ADDR_DIV3 = 8'h2E;
    localparam logic [7:0] ADDR_DIV2 = 8'h2F;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } div_state_e;

    typedef struct packed {
        logic       wr;
        logic       a0;
        logic       a1;
        logic [7:0] din;
    } cpu_bus_t;

    // Terminal count (P-1) for a divider code; the illegal code 3 behaves as /6.
    function automatic logic [CNT_W-1:0] div_period(input logic [CODE_W-1:0] code);
        logic [CNT_W-1:0] pm1;
        case (code)
            DIV3:    pm1 = CNT_W'(2);
            DIV2:    pm1 = CNT_W'(1);
            default: pm1 = CNT_W'(5);
        endcase
        return pm1;
    endfunction

endpackage

// File: rtl/jt12_div_cnt.sv
// Loadable modulo counter: counts 0..period_m1 and flags the terminal-count cycle.
module jt12_div_cnt
    import jt12_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] period_m1,
    input  logic             load,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_nx;

    always_comb begin
        cnt_nx = cnt + CNT_W'(1);
        if (wrap || load) begin
            cnt_nx = '0;
        end
    end

    // wrap is registered by looking one count ahead; period_m1 only changes on the
    // edge where cnt returns to 0, which can never match a terminal count of 1 or more.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            wrap <= (cnt_nx == period_m1);
        end
    end

endmodule

// File: rtl/jt12_div_ctrl.sv
// Prescaler controller: decodes the 0x2D/0x2E/0x2F address writes, swaps the divider only
// on a period boundary and produces cen plus a cen-synchronous internal reset.
module jt12_div_ctrl
    import jt12_div_pkg::*;
#(
    parameter logic [1:0]  DIV_DEFAULT = 2'd0,
    parameter int unsigned SETTLE_CEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_wr,
    input  logic       cpu_a0,
    input  logic       cpu_a1,
    input  logic [7:0] cpu_din,
    output logic       cen,
    output logic       rst_int,
    output logic [1:0] div_sel,
    output logic       busy
);

    localparam logic [CODE_W-1:0]   DIV_INIT    = (DIV_DEFAULT == 2'd3) ? DIV6 : DIV_DEFAULT;
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CEN);

    cpu_bus_t          bus_c;
    logic              req_c;
    logic [CODE_W-1:0] req_code_c;

    div_state_e          state, state_nx;
    logic [CODE_W-1:0]   pend, pend_nx;
    logic [CODE_W-1:0]   div_sel_nx;
    logic                busy_nx;
    logic                rst_int_nx;
    logic                cen_nx;
    logic [SETTLE_W-1:0] settle, settle_nx;

    logic [CNT_W-1:0] period_m1_c;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             load_c;

    // Only part I address-port writes of the three prescaler registers are requests.
    always_comb begin
        bus_c.wr   = cpu_wr;
        bus_c.a0   = cpu_a0;
        bus_c.a1   = cpu_a1;
        bus_c.din  = cpu_din;
        req_c      = 1'b0;
        req_code_c = DIV6;
        if (bus_c.wr && !bus_c.a0 && !bus_c.a1) begin
            case (bus_c.din)
                ADDR_DIV6: begin req_c = 1'b1; req_code_c = DIV6; end
                ADDR_DIV3: begin req_c = 1'b1; req_code_c = DIV3; end
                ADDR_DIV2: begin req_c = 1'b1; req_code_c = DIV2; end
                default:   begin req_c = 1'b0; req_code_c = DIV6; end
            endcase
        end
    end

    assign period_m1_c = div_period(div_sel);

    jt12_div_cnt u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .period_m1 (period_m1_c),
        .load      (load_c),
        .cnt       (cnt),
        .wrap      (wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_HOLD;
            div_sel <= DIV_INIT;
            pend    <= DIV_INIT;
            busy    <= 1'b0;
            rst_int <= 1'b1;
            cen     <= 1'b0;
            settle  <= SETTLE_INIT;
        end else begin
            state   <= state_nx;
            div_sel <= div_sel_nx;
            pend    <= pend_nx;
            busy    <= busy_nx;
            rst_int <= rst_int_nx;
            cen     <= cen_nx;
            settle  <= settle_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        div_sel_nx = div_sel;
        pend_nx    = pend;
        busy_nx    = busy;
        rst_int_nx = rst_int;
        settle_nx  = settle;
        cen_nx     = wrap;
        load_c     = 1'b0;

        case (state)
            ST_HOLD: begin
                rst_int_nx = 1'b1;
                if (wrap) begin
                    if (settle <= SETTLE_W'(1)) begin
                        state_nx   = ST_RUN;
                        rst_int_nx = 1'b0;
                    end else begin
                        settle_nx = settle - SETTLE_W'(1);
                    end
                end
            end

            ST_RUN: begin
                rst_int_nx = 1'b0;
                if (req_c && (req_code_c != div_sel)) begin
                    pend_nx  = req_code_c;
                    busy_nx  = 1'b1;
                    state_nx = ST_PEND;
                end
            end

            ST_PEND: begin
                rst_int_nx = 1'b0;
                if (wrap) begin
                    // Apply the queued code; a request landing on this same wrap waits for the next one.
                    div_sel_nx = pend;
                    load_c     = 1'b1;
                    if (req_c && (req_code_c != pend)) begin
                        pend_nx = req_code_c;
                        busy_nx = 1'b1;
                    end else begin
                        busy_nx  = 1'b0;
                        state_nx = ST_RUN;
                    end
                end else if (req_c) begin
                    if (req_code_c == div_sel) begin
                        pend_nx  = div_sel;
                        busy_nx  = 1'b0;
                        state_nx = ST_RUN;
                    end else begin
                        pend_nx = req_code_c;
                    end
                end
            end

            default: begin
                state_nx = ST_HOLD;
            end
        endcase

        // Resynchronise if the counter is ever found beyond the active period.
        if (cnt > period_m1_c) begin
            load_c = 1'b1;
        end
    end

endmodule

// File: tb/tb_jt12_div_ctrl.sv
// Scoreboard bench for jt12_div_ctrl: stimulus queues the expected cen spacing and status,
// a negedge monitor checks every cen pulse against the queue.
module tb_jt12_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cpu_wr;
    logic       cpu_a0;
    logic       cpu_a1;
    logic [7:0] cpu_din;
    logic       cen;
    logic       rst_int;
    logic [1:0] div_sel;
    logic       busy;

    typedef struct {
        int         intv;
        logic [1:0] dsel;
        logic       bsy;
        logic       rint;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_cen = 0;

    jt12_div_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_wr  (cpu_wr),
        .cpu_a0  (cpu_a0),
        .cpu_a1  (cpu_a1),
        .cpu_din (cpu_din),
        .cen     (cen),
        .rst_int (rst_int),
        .div_sel (div_sel),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int intv, input logic [1:0] ds, input logic b, input logic r);
        exp_t e;
        e.intv = intv;
        e.dsel = ds;
        e.bsy  = b;
        e.rint = r;
        sb.push_back(e);
    endfunction

    // Expected cen train after reset release: rst_int drops together with the third cen.
    function automatic void push_boot();
        push(6, 2'd0, 1'b0, 1'b1);
        push(6, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) push(6, 2'd0, 1'b0, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a1, input logic a0, input logic [7:0] d);
        cpu_wr  = 1'b1;
        cpu_a1  = a1;
        cpu_a0  = a0;
        cpu_din = d;
        tick();
        cpu_wr  = 1'b0;
        cpu_a1  = 1'b0;
        cpu_a0  = 1'b0;
        cpu_din = 8'h00;
    endtask

    task automatic wait_cen(input int n);
        for (int k = 0; k < n; k++) begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (cen) seen = 1'b1;
            end
            check("cen_seen", seen, 1);
        end
    endtask

    // Monitor: interval counted from the clock edge that last sampled reset, or from the previous cen.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            last_cen = cyc + 1;
        end else if (cen) begin
            check("cen_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cen_interval", cyc - last_cen, e.intv);
                check("div_sel_at_cen", div_sel, e.dsel);
                check("busy_at_cen", busy, e.bsy);
                check("rst_int_at_cen", rst_int, e.rint);
            end
            last_cen = cyc;
        end else if (sb.size() != 0 && (cyc - last_cen) > 10) begin
            check("cen_gap_limit", cyc - last_cen, 10);
            sb.delete();
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        cpu_wr  = 1'b0;
        cpu_a0  = 1'b0;
        cpu_a1  = 1'b0;
        cpu_din = 8'h00;
        tick(); tick(); tick();
        check("rst_cen", cen, 0);
        check("rst_rst_int", rst_int, 1);
        check("rst_busy", busy, 0);
        check("rst_div_sel", div_sel, 0);

        // 1: boot with no writes
        push_boot();
        rst_n = 1'b1;
        wait_cen(6);

        // 2: 0x2F at cnt=1 on /6 -> one more 6 then 2s
        push(6, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(2, 2'd2, 1'b0, 1'b0);
        tick();
        wr(1'b0, 1'b0, 8'h2F);
        check("s2_busy_set", busy, 1);
        check("s2_div_sel_held", div_sel, 0);
        wait_cen(4);

        // back to /6 from /2
        push(2, 2'd0, 1'b0, 1'b0);
        wr(1'b0, 1'b0, 8'h2D);
        check("s3a_busy_set", busy, 1);
        wait_cen(1);

        // 3: 0x2E then 0x2F in one /6 period -> straight to /2
        push(6, 2'd2, 1'b0, 1'b0);
        push(2, 2'd2, 1'b0, 1'b0);
        push(2, 2'd2, 1'b0, 1'b0);
        tick();
        wr(1'b0, 1'b0, 8'h2E);
        check("s3_busy_first", busy, 1);
        wr(1'b0, 1'b0, 8'h2F);
        check("s3_busy_second", busy, 1);
        check("s3_div_sel_held", div_sel, 0);
        wait_cen(3);

        push(2, 2'd0, 1'b0, 1'b0);
        wr(1'b0, 1'b0, 8'h2D);
        wait_cen(1);

        // 4: 0x2E on the wrap cycle -> one full extra /6 period
        push(6, 2'd0, 1'b1, 1'b0);
        push(6, 2'd1, 1'b0, 1'b0);
        push(3, 2'd1, 1'b0, 1'b0);
        push(3, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        wr(1'b0, 1'b0, 8'h2E);
        check("s4_busy_on_wrap", busy, 1);
        check("s4_div_sel_held", div_sel, 0);
        wait_cen(3);

        // 5: ignored writes on /3
        for (int i = 0; i < 4; i++) push(3, 2'd1, 1'b0, 1'b0);
        wr(1'b0, 1'b1, 8'h2F);
        check("s5_data_port", busy, 0);
        wr(1'b1, 1'b0, 8'h2F);
        check("s5_part2", busy, 0);
        wr(1'b0, 1'b0, 8'h2C);
        check("s5_other_addr", busy, 0);
        wr(1'b0, 1'b0, 8'h2E);
        check("s5_same_code", busy, 0);
        wait_cen(3);

        // 6: reset while a /3->/2 switch is pending, on the would-be wrap edge
        tick();
        wr(1'b0, 1'b0, 8'h2F);
        check("s6_busy_set", busy, 1);
        rst_n = 1'b0;
        tick();
        check("s6_busy", busy, 0);
        check("s6_rst_int", rst_int, 1);
        check("s6_div_sel", div_sel, 0);
        check("s6_cen", cen, 0);
        push_boot();
        rst_n = 1'b1;
        tick(); tick();
        wr(1'b0, 1'b0, 8'h2F);
        check("s6_hold_ignored", busy, 0);
        wait_cen(6);

        tick(); tick(); tick();
        check("final_div_sel", div_sel, 0);
        check("final_busy", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
